// File: rtl/alu_addsub_pipe.sv
// Pipelined WIDTH-bit add/subtract unit: the carry ripples through NSEG = WIDTH/SEG
// registered segment stages, with valid/ready handshakes on both sides.
module alu_addsub_pipe #(
  parameter int WIDTH = 16,  // multiple of SEG, WIDTH >= SEG
  parameter int SEG   = 4
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             EN,
  input  logic             FLUSH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       OpCode,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow,
  output logic             Negative
);

  localparam int NSEG = WIDTH / SEG;

  // Handshake: a beat is accepted on a rising edge where in_valid & in_ready; a result
  // is consumed on a rising edge where out_valid & out_ready & EN. in_ready = EN &
  // (~out_valid | out_ready), so the whole pipeline shifts together or holds together.
  logic advance;
  assign advance  = EN & (~out_valid | out_ready);
  assign in_ready = advance;

  // SUB/SBB add the inverted operand; carry-in is 0 for ADD, 1 for SUB, Cin otherwise.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  assign b_eff   = OpCode[1] ? ~B : B;
  assign cin_eff = OpCode[0] ? Cin : OpCode[1];

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int IW = WIDTH - k * SEG;  // operand bits not yet summed
    localparam int OW = (k + 1) * SEG;    // result bits known after this stage

    logic [IW-1:0] a_in;
    logic [IW-1:0] b_in;
    logic          c_in;
    logic          v_in;
    logic [SEG:0]  seg_sum;
    logic [OW-1:0] s_nxt;
    logic [OW-1:0] s_q;
    logic          c_q;
    logic          vld_q;

    if (k == 0) begin : g_src
      assign a_in  = A;
      assign b_in  = b_eff;
      assign c_in  = cin_eff;
      assign v_in  = in_valid;
      assign s_nxt = seg_sum[SEG-1:0];
    end else begin : g_src
      assign a_in  = g_stage[k-1].g_fwd.a_q;
      assign b_in  = g_stage[k-1].g_fwd.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].vld_q;
      assign s_nxt = {seg_sum[SEG-1:0], g_stage[k-1].s_q};
    end

    assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= '0;
      end else begin
        if (FLUSH) begin
          vld_q <= 1'b0;
        end else if (advance) begin
          vld_q <= v_in;
        end
        if (advance) begin
          c_q <= seg_sum[SEG];
          s_q <= s_nxt;
        end
      end
    end

    // Only the upper, still-unsummed operand segments travel on to the next stage.
    if (k < NSEG - 1) begin : g_fwd
      logic [IW-SEG-1:0] a_q;
      logic [IW-SEG-1:0] b_q;

      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[IW-1:SEG];
          b_q <= b_in[IW-1:SEG];
        end
      end
    end
  end

  // Flags come from the complete sum formed in the last stage.
  logic [WIDTH-1:0] last_sum;
  logic             last_a_msb;
  logic             last_b_msb;
  logic             zero_q;
  logic             ovf_q;

  assign last_sum   = g_stage[NSEG-1].s_nxt;
  assign last_a_msb = g_stage[NSEG-1].a_in[SEG-1];
  assign last_b_msb = g_stage[NSEG-1].b_in[SEG-1];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (advance) begin
      zero_q <= (last_sum == '0);
      ovf_q  <= (last_a_msb == last_b_msb) && (last_sum[WIDTH-1] != last_a_msb);
    end
  end

  assign out_valid = g_stage[NSEG-1].vld_q;
  assign Result    = g_stage[NSEG-1].s_q;
  assign Carry     = g_stage[NSEG-1].c_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign Negative  = Result[WIDTH-1];

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Bench for alu_addsub_pipe: directed vector table, multi-cycle corner sequences and
// randomized streaming against an arithmetic reference model with an expected queue.
module tb_alu_addsub_pipe;

  localparam int W  = 16;
  localparam int SG = 4;
  localparam int NS = W / SG;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_ADC = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_SBB = 2'd3;

  logic         CLK;
  logic         RST_n;
  logic         EN;
  logic         FLUSH;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [1:0]   OpCode;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic         Zero;
  logic         Carry;
  logic         Overflow;
  logic         Negative;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  logic [W+3:0] exp_q[$];

  alu_addsub_pipe #(.WIDTH(W), .SEG(SG)) dut (
    .CLK(CLK), .RST_n(RST_n), .EN(EN), .FLUSH(FLUSH),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .OpCode(OpCode), .Cin(Cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Zero(Zero), .Carry(Carry), .Overflow(Overflow), .Negative(Negative)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic do_reset();
    RST_n = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Returns {Result, Zero, Carry, Overflow, Negative} from whole-number arithmetic.
  function automatic logic [W+3:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic ci);
    longint ua, ub, sa, sb, ex, sx, bw, smax, smin;
    logic [W-1:0] r;
    logic c, v;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    bw   = 0;
    case (op)
      OP_ADD:  begin ex = ua + ub;                 sx = sa + sb; end
      OP_ADC:  begin ex = ua + ub + longint'(ci);  sx = sa + sb + longint'(ci); end
      OP_SUB:  begin ex = ua - ub;                 sx = sa - sb; end
      default: begin bw = ci ? 0 : 1; ex = ua - ub - bw; sx = sa - sb - bw; end
    endcase
    if (op[1]) c = (ex >= 0);
    else       c = (ex >= (longint'(1) <<< W));
    r = ex[W-1:0];
    v = (sx > smax) || (sx < smin);
    return {r, (r == '0), c, v, r[W-1]};
  endfunction

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  // Samples one time unit before each rising edge, when all inputs are settled.
  logic         p_valid = 1'b0;
  logic         p_hold  = 1'b0;
  logic [W-1:0] p_res   = '0;

  always begin
    logic [W+3:0] exp_v;
    logic         adv;
    @(negedge CLK);
    #4;
    if (RST_n !== 1'b1) begin
      exp_q.delete();
      p_hold = 1'b0;
    end else begin
      adv = EN & (~out_valid | out_ready);
      check("in_ready_rule", 64'(in_ready), 64'(adv));
      if (p_hold) begin
        check("stall_valid_held", 64'(out_valid), 64'(p_valid));
        check("stall_result_held", 64'(Result), 64'(p_res));
      end
      if (FLUSH) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready && EN) begin
          n_out++;
          if (exp_q.size() == 0) begin
            check("unexpected_result", 64'(1), 64'(0));
          end else begin
            exp_v = exp_q.pop_front();
            check("sb_result", 64'({Result, Zero, Carry, Overflow, Negative}), 64'(exp_v));
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(OpCode, A, B, Cin));
      end
      p_hold  = !adv && !FLUSH;
      p_valid = out_valid;
      p_res   = Result;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci);
    logic acc;
    acc = 1'b0;
    @(negedge CLK);
    in_valid = 1'b1; OpCode = op; A = a; B = b; Cin = ci;
    for (int t = 0; t < 64 && !acc; t++) begin
      if (t > 0) @(negedge CLK);
      #1 acc = in_ready;
      @(posedge CLK);
    end
    #1 in_valid = 1'b0;
    check("beat_accepted", 64'(acc), 64'(1));
  endtask

  // Called just after the accepting edge; counts edges until out_valid rises.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 32) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    check("out_valid_timeout", 64'(out_valid), 64'(1));
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
    logic         n;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat;
    int base;
    int sent;
    int cyc;
    logic [3:0] pat;
    logic [W+3:0] e;

    vecs[0] = '{op: OP_SUB, a: 16'h5678, b: 16'h1234, ci: 1'b0, r: 16'h4444, z: 1'b0, c: 1'b1, v: 1'b0, n: 1'b0};
    vecs[1] = '{op: OP_SUB, a: 16'h0000, b: 16'h0001, ci: 1'b0, r: 16'hFFFF, z: 1'b0, c: 1'b0, v: 1'b0, n: 1'b1};
    vecs[2] = '{op: OP_SUB, a: 16'hABCD, b: 16'hABCD, ci: 1'b0, r: 16'h0000, z: 1'b1, c: 1'b1, v: 1'b0, n: 1'b0};
    vecs[3] = '{op: OP_ADD, a: 16'h7FFF, b: 16'h0001, ci: 1'b0, r: 16'h8000, z: 1'b0, c: 1'b0, v: 1'b1, n: 1'b1};
    vecs[4] = '{op: OP_ADD, a: 16'hFFFF, b: 16'h0001, ci: 1'b0, r: 16'h0000, z: 1'b1, c: 1'b1, v: 1'b0, n: 1'b0};
    vecs[5] = '{op: OP_ADC, a: 16'h0000, b: 16'h0000, ci: 1'b1, r: 16'h0001, z: 1'b0, c: 1'b0, v: 1'b0, n: 1'b0};
    vecs[6] = '{op: OP_SBB, a: 16'h0000, b: 16'h0000, ci: 1'b0, r: 16'hFFFF, z: 1'b0, c: 1'b0, v: 1'b0, n: 1'b1};
    vecs[7] = '{op: OP_ADD, a: 16'h8000, b: 16'h8000, ci: 1'b0, r: 16'h0000, z: 1'b1, c: 1'b1, v: 1'b1, n: 1'b0};
    vecs[8] = '{op: OP_SBB, a: 16'h8000, b: 16'h0001, ci: 1'b1, r: 16'h7FFF, z: 1'b0, c: 1'b1, v: 1'b1, n: 1'b0};
    vecs[9] = '{op: OP_ADC, a: 16'h7FFF, b: 16'h0000, ci: 1'b1, r: 16'h8000, z: 1'b0, c: 1'b0, v: 1'b1, n: 1'b1};

    RST_n = 1'b0; EN = 1'b1; FLUSH = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; OpCode = OP_ADD; Cin = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("reset_outputs", 64'({out_valid, Result, Zero, Carry, Overflow, Negative}), 64'(0));
    do_reset();
    check("post_reset_idle", 64'(out_valid), 64'(0));

    // Directed vectors, one at a time, with latency check
    foreach (vecs[i]) begin
      drive_beat(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci);
      wait_out(lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(NS));
      check($sformatf("vec%0d_result", i), 64'(Result), 64'(vecs[i].r));
      check($sformatf("vec%0d_flags", i), 64'({Zero, Carry, Overflow, Negative}),
            64'({vecs[i].z, vecs[i].c, vecs[i].v, vecs[i].n}));
    end
    repeat (2) @(posedge CLK);

    // 32-bit chain, back-to-back: low word then high word on consecutive cycles
    drive_beat(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    drive_beat(OP_ADC, 16'h0000, 16'h0000, 1'b1);
    wait_out(lat);
    check("chain_add_lat", 64'(lat), 64'(NS - 1));
    check("chain_add_lo", 64'({Result, Carry}), 64'({16'h0000, 1'b1}));
    @(posedge CLK); #1;
    check("chain_add_hi", 64'({out_valid, Result, Carry}), 64'({1'b1, 16'h0001, 1'b0}));
    drive_beat(OP_SUB, 16'h0000, 16'h0001, 1'b0);
    drive_beat(OP_SBB, 16'h0000, 16'h0000, 1'b0);
    wait_out(lat);
    check("chain_sub_lo", 64'({Result, Carry}), 64'({16'hFFFF, 1'b0}));
    @(posedge CLK); #1;
    check("chain_sub_hi", 64'({out_valid, Result, Carry}), 64'({1'b1, 16'hFFFF, 1'b0}));
    repeat (NS + 2) @(posedge CLK);

    // Stream 8 beats while out_ready follows 1,0,0,1
    pat  = 4'b1001;
    base = n_out;
    sent = 0;
    cyc  = 0;
    while (sent < 8 && cyc < 200) begin
      @(negedge CLK);
      out_ready = pat[cyc % 4];
      in_valid  = 1'b1;
      OpCode    = 2'($urandom_range(0, 3));
      A         = rand_operand();
      B         = rand_operand();
      Cin       = 1'($urandom_range(0, 1));
      #1;
      if (in_ready) sent++;
      cyc++;
    end
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (NS + 6) @(negedge CLK);
    check("stream_count", 64'(n_out - base), 64'(8));

    // FLUSH with three beats in flight
    drive_beat(OP_ADD, 16'h1111, 16'h2222, 1'b0);
    drive_beat(OP_ADD, 16'h3333, 16'h4444, 1'b0);
    drive_beat(OP_SUB, 16'h9999, 16'h1111, 1'b0);
    @(negedge CLK); FLUSH = 1'b1;
    @(posedge CLK); #1 FLUSH = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("flush_idle", 64'(out_valid), 64'(0));
      @(posedge CLK); #1;
    end
    drive_beat(OP_SUB, 16'h5678, 16'h1234, 1'b0);
    wait_out(lat);
    check("after_flush_latency", 64'(lat), 64'(NS));
    e = model(OP_SUB, 16'h5678, 16'h1234, 1'b0);
    check("after_flush_result", 64'({Result, Zero, Carry, Overflow, Negative}), 64'(e));
    repeat (3) @(posedge CLK);

    // Asynchronous reset mid-stream
    drive_beat(OP_ADD, 16'h0F0F, 16'h0101, 1'b0);
    drive_beat(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
    drive_beat(OP_SUB, 16'h0000, 16'h0001, 1'b0);
    @(posedge CLK); #1;
    check("pre_reset_valid", 64'({out_valid, Result}), 64'({1'b1, 16'h1010}));
    @(negedge CLK);
    #2 RST_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'({out_valid, Result, Zero, Carry, Overflow, Negative}), 64'(0));
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST_n = 1'b1;
    drive_beat(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    wait_out(lat);
    check("after_reset_latency", 64'(lat), 64'(NS));
    check("after_reset_result", 64'({Result, Zero, Carry}), 64'({16'h0000, 1'b1, 1'b1}));
    repeat (3) @(posedge CLK);

    // Randomized traffic with back-pressure, EN gaps and occasional flushes
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      EN        = ($urandom_range(0, 15) != 0);
      FLUSH     = ($urandom_range(0, 79) == 0);
      OpCode    = 2'($urandom_range(0, 3));
      A         = rand_operand();
      B         = rand_operand();
      Cin       = 1'($urandom_range(0, 1));
    end
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b1; EN = 1'b1; FLUSH = 1'b0;
    repeat (NS + 8) @(negedge CLK);
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_addsub_pipe.md
Name: alu_addsub_pipe

Overview:
Parametrised, pipelined add/subtract unit; next-generation arithmetic path for the ALU family, generalising the 16-bit single-cycle add/sub to WIDTH bits.
Carry ripples through NSEG = WIDTH/SEG registered segment stages, one segment per cycle, with valid/ready handshakes on both sides.
Carry/borrow convention is unchanged from the existing ALU: for subtract, carry = 1 means no borrow.
Sits between operand issue logic and result writeback; supports multi-word chaining via ADC/SBB.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of SEG, WIDTH >= SEG.
SEG, 4, bits computed per pipeline stage; NSEG = WIDTH/SEG = latency in cycles.

Ports:
CLK  in  1  clock, rising edge.
RST_n  in  1  asynchronous active-low reset.
EN  in  1  global enable; 0 freezes the pipeline.
FLUSH  in  1  synchronous; clears all in-flight valids.
in_valid  in  1  operand beat valid.
in_ready  out  1  unit accepts a beat this cycle.
A  in  WIDTH  operand A.
B  in  WIDTH  operand B.
OpCode  in  2  0=ADD, 1=ADC, 2=SUB, 3=SBB.
Cin  in  1  carry-in for ADC/SBB (SBB: 1 = no borrow).
out_valid  out  1  Result/flags valid.
out_ready  in  1  downstream accepts result.
Result  out  WIDTH  A op B.
Zero  out  1  Result == 0 (full width).
Carry  out  1  carry out of MSB (SUB/SBB: 1 = no borrow).
Overflow  out  1  signed overflow.
Negative  out  1  Result[WIDTH-1].

Behaviour:
- Async reset (RST_n=0): all stage valids, out_valid, Result and flags = 0, immediately and independent of CLK.
- Operand mux at acceptance:
  - b_eff = B for ADD/ADC, ~B for SUB/SBB.
  - cin_eff = 0 (ADD), Cin (ADC), 1 (SUB), Cin (SBB).
- advance = EN & (~out_valid | out_ready); in_ready = advance (combinational). A beat is accepted when in_valid & in_ready.
- Stage k (0..NSEG-1):
  - Adds segment k of A and b_eff plus carry from stage k-1; stage 0 uses cin_eff.
  - Registers the partial sum, carry-out, and the still-unprocessed upper operand segments.
  - Already-computed lower result segments travel with the beat (deskew), so Result leaves whole.
- Latency: a beat accepted at edge n gives out_valid=1 after edge n+NSEG-1 (NSEG edges total), with no stalls. Throughput is 1 beat/cycle.
- Flags are computed in the last stage from the full result:
  - Overflow = (A[msb] == b_eff[msb]) & (Result[msb] != A[msb]).
  - Carry = carry-out of the final segment.
- Stall: whole pipeline holds when advance=0; Result, flags and out_valid stay stable while out_valid & ~out_ready.
- Bubbles: a stage with valid=0 shifts as a bubble; out_valid=0 does not stall upstream.
- Simultaneous accept and emit in the same cycle is legal; no beat is lost or duplicated.
- EN=0: in_ready=0, state frozen, outputs held. FLUSH beats EN.
- FLUSH=1 at an edge: all valids, including out_valid, become 0. The input beat in that cycle is dropped. Data registers may keep stale values.
- Reset mid-operation: all in-flight beats are discarded; the first beat after reset release behaves as from idle.
- Wrap-around: results are modulo 2^WIDTH; carry and borrow are reported only via Carry.
- NSEG=1 degenerates to a single registered stage with identical semantics.

Test Plan:
1. WIDTH=16, SEG=4, SUB: A=5678, B=1234 -> after 4 cycles Result=4444, Carry=1, Zero=0, Overflow=0, Negative=0.
2. SUB: A=0000, B=0001 -> Result=FFFF, Carry=0 (borrow), Negative=1, Overflow=0. Then SUB A=B=ABCD -> Result=0000, Zero=1, Carry=1.
3. ADD: 7FFF+0001 -> 8000, Overflow=1, Negative=1. ADD: FFFF+0001 -> 0000, Carry=1, Zero=1, Overflow=0.
4. 32-bit chain over two beats, back-to-back:
   - Beat 1: ADD 0xFFFF+0x0001 -> Carry=1.
   - Beat 2: ADC 0x0000+0x0000 with Cin=1 -> Result=0001.
   - Repeat with SUB/SBB on 0x0000_0000 - 0x0000_0001 -> FFFF/Carry=0 then FFFF.
5. Stream 8 beats at in_valid=1 while toggling out_ready (1,0,0,1,...) -> every result appears exactly once, in order. Result is stable while stalled. in_ready=0 whenever out_valid & ~out_ready.
6. Assert FLUSH with 3 beats in flight -> out_valid stays 0 until a new beat arrives NSEG cycles later. Drop RST_n mid-stream -> outputs 0 asynchronously, and the next beat's latency is exactly 4.
